// File: rtl/aha_clock_select_seq_if.sv
// Request/response bundle between a clock-select requester and the
// break-before-make sequencer, including the per-channel enable/ack wires.
interface aha_clock_select_seq_if #(
  parameter int NUM_CLK = 6,
  parameter int SEL_W   = 3,
  parameter int TMO_W   = 8
) ();

  logic [SEL_W-1:0]   select_req;
  logic               select_valid;
  logic               select_ready;
  logic [TMO_W-1:0]   timeout_val;
  logic [NUM_CLK-1:0] ch_en;
  logic [NUM_CLK-1:0] ch_ack;
  logic [SEL_W-1:0]   cur_sel;
  logic               busy;
  logic [1:0]         err_code;
  logic               err_clr;

  // Requester side: issues selects, owns the timeout limit and error clear,
  // and returns the channel acknowledges.
  modport master (
    output select_req, select_valid, timeout_val, ch_ack, err_clr,
    input  select_ready, ch_en, cur_sel, busy, err_code
  );

  // Sequencer side.
  modport slave (
    input  select_req, select_valid, timeout_val, ch_ack, err_clr,
    output select_ready, ch_en, cur_sel, busy, err_code
  );

endinterface

// File: rtl/aha_clock_select_seq.sv
// Centralised break-before-make clock select sequencer. Runs on an always-on
// reference clock, releases the old channel, waits for its ack to drop, waits a
// settle gap, enables the new channel and waits for its ack. Ack waits can be
// bounded by a timeout, and errors are latched in a sticky error code.
module aha_clock_select_seq #(
  parameter int NUM_CLK       = 6,
  parameter int SEL_W         = 3,
  parameter int RESET_SEL     = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int TMO_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  aha_clock_select_seq_if.slave bus
);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    RELEASE,
    SETTLE,
    ENABLE
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   NUM_CLK_V   = (SEL_W + 1)'(NUM_CLK);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RELEASE = 2'd1;
  localparam logic [1:0] ERR_ENABLE  = 2'd2;
  localparam logic [1:0] ERR_BADSEL  = 2'd3;

  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_CLK'(1) << idx;
  endfunction

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   target_q, target_n;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_n;
  logic [NUM_CLK-1:0] ch_en_q, ch_en_n;
  logic [TMO_W-1:0]   tmo_q, tmo_n;
  logic [SET_W-1:0]   settle_q, settle_n;
  logic [1:0]         err_q, err_n;
  logic [1:0]         new_err;
  logic [NUM_CLK-1:0] ack_meta, ack_s;
  logic [TMO_W:0]     tmo_inc;
  logic               tmo_hit;
  logic               cur_ack, tgt_ack;
  logic               accept;

  // Two-flop synchroniser bringing the channel-domain acks onto the reference clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_meta <= '0;
      ack_s    <= '0;
    end else begin
      ack_meta <= bus.ch_ack;
      ack_s    <= ack_meta;
    end
  end

  // State and datapath registers; a reset mid-sequence drops every channel and reboots.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT;
      target_q  <= RESET_SEL_V;
      cur_sel_q <= RESET_SEL_V;
      ch_en_q   <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_n;
      target_q  <= target_n;
      cur_sel_q <= cur_sel_n;
      ch_en_q   <= ch_en_n;
      tmo_q     <= tmo_n;
      settle_q  <= settle_n;
      err_q     <= err_n;
    end
  end

  // Next-state logic: release old channel, settle, enable new channel, with bounded ack waits.
  always_comb begin
    state_n   = state_q;
    target_n  = target_q;
    cur_sel_n = cur_sel_q;
    ch_en_n   = ch_en_q;
    tmo_n     = tmo_q;
    settle_n  = settle_q;
    new_err   = ERR_NONE;

    accept  = bus.select_valid && (state_q == IDLE);
    cur_ack = |(ack_s & onehot(cur_sel_q));
    tgt_ack = |(ack_s & onehot(target_q));
    tmo_inc = {1'b0, tmo_q} + 1'b1;
    tmo_hit = (bus.timeout_val != '0) && (tmo_inc >= {1'b0, bus.timeout_val});

    case (state_q)
      BOOT: begin
        target_n  = RESET_SEL_V;
        cur_sel_n = RESET_SEL_V;
        ch_en_n   = onehot(RESET_SEL_V);
        tmo_n     = '0;
        state_n   = ENABLE;
      end

      IDLE: begin
        if (accept) begin
          if ({1'b0, bus.select_req} >= NUM_CLK_V) begin
            new_err = ERR_BADSEL;
          end else if (bus.select_req != cur_sel_q) begin
            target_n = bus.select_req;
            ch_en_n  = '0;
            tmo_n    = '0;
            state_n  = RELEASE;
          end
        end
      end

      RELEASE: begin
        if (!cur_ack) begin
          settle_n = '0;
          state_n  = SETTLE;
        end else if (tmo_hit) begin
          new_err  = ERR_RELEASE;
          settle_n = '0;
          state_n  = SETTLE;
        end else if (tmo_q != '1) begin
          tmo_n = tmo_inc[TMO_W-1:0];
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          ch_en_n   = onehot(target_q);
          cur_sel_n = target_q;
          tmo_n     = '0;
          state_n   = ENABLE;
        end else begin
          settle_n = settle_q + 1'b1;
        end
      end

      ENABLE: begin
        if (tgt_ack) begin
          state_n = IDLE;
        end else if (tmo_hit) begin
          new_err = ERR_ENABLE;
          state_n = IDLE;
        end else if (tmo_q != '1) begin
          tmo_n = tmo_inc[TMO_W-1:0];
        end
      end

      default: begin
        state_n = BOOT;
        ch_en_n = '0;
      end
    endcase

    if (new_err != ERR_NONE) begin
      err_n = new_err;
    end else if (bus.err_clr) begin
      err_n = ERR_NONE;
    end else begin
      err_n = err_q;
    end
  end

  assign bus.select_ready = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.ch_en        = ch_en_q;
  assign bus.cur_sel      = cur_sel_q;
  assign bus.err_code     = err_q;

endmodule
